// File: rtl/traffic_phase_ctrl_pkg.sv
// Shared codes for the traffic phase sequencer: phase encodings, mode and
// config-select codes, lamp bit positions and the owning-direction lamp map.
package traffic_phase_ctrl_pkg;

  typedef enum logic [1:0] {
    PH_GREEN  = 2'd0,
    PH_YELLOW = 2'd1,
    PH_ALLRED = 2'd2
  } phase_e;

  // mode_i codes; 2'd3 behaves like normal
  localparam logic [1:0] MODE_NORMAL = 2'd0;
  localparam logic [1:0] MODE_FLASH  = 2'd1;
  localparam logic [1:0] MODE_HOLD   = 2'd2;

  // cfg_sel_i codes
  localparam logic [1:0] SEL_NONE = 2'd0;
  localparam logic [1:0] SEL_GR   = 2'd1;
  localparam logic [1:0] SEL_YR   = 2'd2;
  localparam logic [1:0] SEL_RR   = 2'd3;

  // Bit positions inside one direction's {red,yellow,green} lamp triple
  localparam int LIGHT_GRN = 0;
  localparam int LIGHT_YEL = 1;
  localparam int LIGHT_RED = 2;

  // Lamp triple shown by the direction that currently owns the phase
  function automatic logic [2:0] owner_lamp(phase_e ph);
    logic [2:0] l;
    l = '0;
    case (ph)
      PH_GREEN:  l[LIGHT_GRN] = 1'b1;
      PH_YELLOW: l[LIGHT_YEL] = 1'b1;
      default:   l[LIGHT_RED] = 1'b1;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/traffic_phase_ctrl_phase_len_cfg.sv
// Runtime-adjustable green/yellow/all-red lengths with saturating
// default/increment/decrement controls. Lengths never reach zero.
module traffic_phase_ctrl_phase_len_cfg
  import traffic_phase_ctrl_pkg::*;
#(
  parameter int TIME_W = 4,
  parameter int GR_DEF = 10,
  parameter int YR_DEF = 3,
  parameter int RR_DEF = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [1:0]        cfg_sel_i,
  input  logic              cfg_def_i,
  input  logic              cfg_inc_i,
  input  logic              cfg_dec_i,
  output logic [TIME_W-1:0] gr_len,
  output logic [TIME_W-1:0] yr_len,
  output logic [TIME_W-1:0] rr_len
);

  localparam logic [TIME_W-1:0] LEN_MAX = {TIME_W{1'b1}};
  localparam logic [TIME_W-1:0] LEN_MIN = TIME_W'(1);

  // def wins over inc, inc over dec; both directions saturate
  function automatic logic [TIME_W-1:0] adjust(logic [TIME_W-1:0] cur,
                                               logic [TIME_W-1:0] dflt);
    if (cfg_def_i)      return dflt;
    else if (cfg_inc_i) return (cur == LEN_MAX) ? cur : cur + 1'b1;
    else if (cfg_dec_i) return (cur > LEN_MIN) ? cur - 1'b1 : cur;
    else                return cur;
  endfunction

  // Update only the selected length register; SEL_NONE ignores all pulses
  always_ff @(posedge clk_i) begin
    // NOTE: registers take <= so every flop samples pre-edge values, exactly as the hardware does.
    if (rst_i) begin
      gr_len <= TIME_W'(GR_DEF);
      yr_len <= TIME_W'(YR_DEF);
      rr_len <= TIME_W'(RR_DEF);
    end else begin
      case (cfg_sel_i)
        SEL_GR:  gr_len <= adjust(gr_len, TIME_W'(GR_DEF));
        SEL_YR:  yr_len <= adjust(yr_len, TIME_W'(YR_DEF));
        SEL_RR:  rr_len <= adjust(rr_len, TIME_W'(RR_DEF));
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// N-direction traffic-light sequencer stepped by a 1 Hz tick enable.
// Each direction runs GREEN -> YELLOW -> ALLRED, then hands over to the next.
// Supports flash, hold and latched pedestrian requests that shorten green.
module traffic_phase_ctrl
  import traffic_phase_ctrl_pkg::*;
#(
  parameter int NUM_DIR = 2,
  parameter int TIME_W  = 4,
  parameter int GR_DEF  = 10,
  parameter int YR_DEF  = 3,
  parameter int RR_DEF  = 1,
  parameter int PED_MIN = 3
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       tick_i,
  input  logic [1:0]                 mode_i,
  input  logic [1:0]                 cfg_sel_i,
  input  logic                       cfg_def_i,
  input  logic                       cfg_inc_i,
  input  logic                       cfg_dec_i,
  input  logic [NUM_DIR-1:0]         ped_req_i,
  output logic [3*NUM_DIR-1:0]       light_o,
  output logic [TIME_W-1:0]          time_o,
  output logic [$clog2(NUM_DIR)-1:0] dir_o
);

  localparam int                DIR_W    = $clog2(NUM_DIR);
  localparam logic [DIR_W-1:0]  LAST_DIR = DIR_W'(NUM_DIR - 1);
  localparam logic [TIME_W-1:0] PED_CNT  = TIME_W'(PED_MIN);

  logic [TIME_W-1:0] gr_len, yr_len, rr_len;

  traffic_phase_ctrl_phase_len_cfg #(
    .TIME_W (TIME_W),
    .GR_DEF (GR_DEF),
    .YR_DEF (YR_DEF),
    .RR_DEF (RR_DEF)
  ) u_len_cfg (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .cfg_sel_i (cfg_sel_i),
    .cfg_def_i (cfg_def_i),
    .cfg_inc_i (cfg_inc_i),
    .cfg_dec_i (cfg_dec_i),
    .gr_len    (gr_len),
    .yr_len    (yr_len),
    .rr_len    (rr_len)
  );

  phase_e                 state_q, state_d;
  logic [DIR_W-1:0]       dir_q, dir_d;
  logic [TIME_W-1:0]      cnt_q, cnt_d;
  logic [NUM_DIR-1:0]     ped_q, ped_d, ped_eff;
  logic                   flash_q, flash_d;
  logic                   in_flash_q, in_flash_d;
  logic [3*NUM_DIR-1:0]   light_d;
  logic [TIME_W-1:0]      time_d;

  // Next-state: flash/exit-flash/hold/normal sequencing, ped cut, output images
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d    = state_q;
    dir_d      = dir_q;
    cnt_d      = cnt_q;
    flash_d    = flash_q;
    ped_eff    = ped_q | ped_req_i;
    ped_d      = ped_eff;
    in_flash_d = (mode_i == MODE_FLASH);
    light_d    = '0;
    time_d     = '0;

    if (mode_i == MODE_FLASH) begin
      if (tick_i) flash_d = ~flash_q;
    end else if (in_flash_q) begin
      // Park in all-red of the last direction so dir 0 green follows safely
      state_d = PH_ALLRED;
      dir_d   = LAST_DIR;
      cnt_d   = rr_len;
    end else if (mode_i != MODE_HOLD) begin
      if (state_q == PH_GREEN && ped_eff[dir_q] && cnt_q > PED_CNT) begin
        cnt_d = PED_CNT;
      end else if (tick_i) begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          case (state_q)
            PH_GREEN: begin
              state_d      = PH_YELLOW;
              cnt_d        = yr_len;
              ped_d[dir_q] = 1'b0;
            end
            PH_YELLOW: begin
              state_d = PH_ALLRED;
              cnt_d   = rr_len;
            end
            default: begin
              state_d = PH_GREEN;
              dir_d   = (dir_q == LAST_DIR) ? '0 : dir_q + 1'b1;
              cnt_d   = gr_len;
            end
          endcase
        end
      end
    end

    for (int d = 0; d < NUM_DIR; d++) begin
      if (in_flash_d) begin
        light_d[3*d+LIGHT_YEL] = flash_d;
      end else if (d == int'(dir_d)) begin
        light_d[3*d +: 3] = owner_lamp(state_d);
      end else begin
        light_d[3*d+LIGHT_RED] = 1'b1;
      end
    end

    case (cfg_sel_i)
      SEL_GR:  time_d = gr_len;
      SEL_YR:  time_d = yr_len;
      SEL_RR:  time_d = rr_len;
      default: time_d = cnt_d;
    endcase
  end

  // Phase FSM state, latches and registered outputs with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= PH_GREEN;
      dir_q      <= '0;
      cnt_q      <= TIME_W'(GR_DEF);
      ped_q      <= '0;
      flash_q    <= 1'b0;
      in_flash_q <= 1'b0;
      time_o     <= TIME_W'(GR_DEF);
      dir_o      <= '0;
      for (int d = 0; d < NUM_DIR; d++) begin
        light_o[3*d +: 3] <= (d == 0) ? owner_lamp(PH_GREEN) : owner_lamp(PH_ALLRED);
      end
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      cnt_q      <= cnt_d;
      ped_q      <= ped_d;
      flash_q    <= flash_d;
      in_flash_q <= in_flash_d;
      light_o    <= light_d;
      time_o     <= time_d;
      dir_o      <= dir_d;
    end
  end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed scoreboard bench for traffic_phase_ctrl with NUM_DIR=2 defaults.
module tb_traffic_phase_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       tick_i = 1'b0;
  logic [1:0] mode_i = 2'd0;
  logic [1:0] cfg_sel_i = 2'd0;
  logic       cfg_def_i = 1'b0;
  logic       cfg_inc_i = 1'b0;
  logic       cfg_dec_i = 1'b0;
  logic [1:0] ped_req_i = 2'b00;
  logic [5:0] light_o;
  logic [3:0] time_o;
  logic [0:0] dir_o;

  int n_tests = 0;
  int n_fail  = 0;

  // {dir1 r,y,g , dir0 r,y,g}
  localparam logic [5:0] L_G0   = 6'b100_001;
  localparam logic [5:0] L_Y0   = 6'b100_010;
  localparam logic [5:0] L_AR   = 6'b100_100;
  localparam logic [5:0] L_G1   = 6'b001_100;
  localparam logic [5:0] L_Y1   = 6'b010_100;
  localparam logic [5:0] L_FON  = 6'b010_010;
  localparam logic [5:0] L_FOFF = 6'b000_000;

  typedef struct {
    string      tag;
    logic [5:0] light;
    logic [3:0] tval;
    logic [0:0] dir;
  } exp_t;

  exp_t sb_q[$];

  traffic_phase_ctrl dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .tick_i    (tick_i),
    .mode_i    (mode_i),
    .cfg_sel_i (cfg_sel_i),
    .cfg_def_i (cfg_def_i),
    .cfg_inc_i (cfg_inc_i),
    .cfg_dec_i (cfg_dec_i),
    .ped_req_i (ped_req_i),
    .light_o   (light_o),
    .time_o    (time_o),
    .dir_o     (dir_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(string tag, logic [31:0] observed, logic [31:0] expected);
    n_tests++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d required %0d", tag, observed, expected);
    end
  endtask

  // Inputs change 1 time unit after an edge; outputs are sampled there too
  task automatic clk1();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clk_n(int n);
    repeat (n) clk1();
  endtask

  task automatic tick_n(int n);
    repeat (n) begin
      tick_i = 1'b1;
      clk1();
      tick_i = 1'b0;
    end
  endtask

  task automatic push_exp(string tag, logic [5:0] l, logic [3:0] t, logic [0:0] d);
    exp_t e;
    e.tag = tag; e.light = l; e.tval = t; e.dir = d;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({e.tag, ".light"}, 32'(light_o), 32'(e.light));
      check({e.tag, ".time"},  32'(time_o),  32'(e.tval));
      check({e.tag, ".dir"},   32'(dir_o),   32'(e.dir));
    end
  endtask

  // Expectation queued before the ticks are driven, compared afterwards
  task automatic ticks_expect(int n, string tag, logic [5:0] l, logic [3:0] t, logic [0:0] d);
    push_exp(tag, l, t, d);
    tick_n(n);
    drain();
  endtask

  task automatic clks_expect(int n, string tag, logic [5:0] l, logic [3:0] t, logic [0:0] d);
    push_exp(tag, l, t, d);
    clk_n(n);
    drain();
  endtask

  task automatic cfg_pulse(int n, logic def, logic inc, logic dec);
    repeat (n) begin
      cfg_def_i = def; cfg_inc_i = inc; cfg_dec_i = dec;
      clk1();
      cfg_def_i = 1'b0; cfg_inc_i = 1'b0; cfg_dec_i = 1'b0;
    end
  endtask

  initial begin
    // 1: reset and a full default cycle
    clks_expect(2, "reset", L_G0, 4'd10, 1'b0);
    rst_i = 1'b0;
    ticks_expect(10, "g0_end",   L_G0, 4'd0,  1'b0);
    ticks_expect(1,  "y0_start", L_Y0, 4'd3,  1'b0);
    ticks_expect(3,  "y0_end",   L_Y0, 4'd0,  1'b0);
    ticks_expect(1,  "ar0",      L_AR, 4'd1,  1'b0);
    ticks_expect(1,  "ar0_end",  L_AR, 4'd0,  1'b0);
    ticks_expect(1,  "g1_start", L_G1, 4'd10, 1'b1);
    ticks_expect(17, "g0_again", L_G0, 4'd10, 1'b0);

    // 2: green length saturation and def-over-inc priority
    cfg_sel_i = 2'd1;
    cfg_pulse(20, 1'b0, 1'b1, 1'b0);
    clks_expect(1, "gr_sat_hi", L_G0, 4'd15, 1'b0);
    cfg_pulse(20, 1'b0, 1'b0, 1'b1);
    clks_expect(1, "gr_sat_lo", L_G0, 4'd1, 1'b0);
    cfg_pulse(1, 1'b1, 1'b1, 1'b0);
    clks_expect(1, "gr_def_prio", L_G0, 4'd10, 1'b0);
    cfg_sel_i = 2'd0;
    clks_expect(1, "cnt_untouched", L_G0, 4'd10, 1'b0);

    // 3: pedestrian cut on dir 0 green
    ticks_expect(2, "ped_pre", L_G0, 4'd8, 1'b0);
    ped_req_i = 2'b01;
    clk1();
    ped_req_i = 2'b00;
    clks_expect(1, "ped_cut",   L_G0, 4'd3, 1'b0);
    ticks_expect(3, "ped_g_end", L_G0, 4'd0, 1'b0);
    ticks_expect(1, "ped_y",     L_Y0, 4'd3, 1'b0);
    ticks_expect(23, "ped_next_g0", L_G0, 4'd10, 1'b0);
    clks_expect(3, "ped_latch_clr", L_G0, 4'd10, 1'b0);

    // 4: flash mid-green, then exit to all-red
    ticks_expect(2, "fl_pre", L_G0, 4'd8, 1'b0);
    mode_i = 2'd1;
    clks_expect(1, "fl_enter", L_FOFF, 4'd8, 1'b0);
    ticks_expect(1, "fl_on1",  L_FON,  4'd8, 1'b0);
    ticks_expect(1, "fl_off",  L_FOFF, 4'd8, 1'b0);
    ticks_expect(1, "fl_on2",  L_FON,  4'd8, 1'b0);
    mode_i = 2'd0;
    clks_expect(1, "fl_exit", L_AR, 4'd1, 1'b1);
    ticks_expect(1, "fl_ar_end", L_AR, 4'd0, 1'b1);
    ticks_expect(1, "fl_g0",     L_G0, 4'd10, 1'b0);

    // 5: hold freezes sequencing; config still applies
    ticks_expect(1, "hold_pre", L_G0, 4'd9, 1'b0);
    mode_i = 2'd2;
    ticks_expect(5, "hold_frozen", L_G0, 4'd9, 1'b0);
    cfg_sel_i = 2'd2;
    cfg_pulse(1, 1'b0, 1'b1, 1'b0);
    clks_expect(1, "hold_yr_inc", L_G0, 4'd4, 1'b0);
    cfg_sel_i = 2'd0;
    clks_expect(1, "hold_cnt", L_G0, 4'd9, 1'b0);
    mode_i = 2'd0;
    ticks_expect(9, "hold_g_end", L_G0, 4'd0, 1'b0);
    ticks_expect(1, "hold_y_new", L_Y0, 4'd4, 1'b0);

    // 6: synchronous reset during dir 1 yellow, tick coinciding
    ticks_expect(18, "pre_rst_y1", L_Y1, 4'd4, 1'b1);
    rst_i  = 1'b1;
    tick_i = 1'b1;
    push_exp("sync_rst", L_G0, 4'd10, 1'b0);
    clk1();
    rst_i  = 1'b0;
    tick_i = 1'b0;
    drain();
    ticks_expect(11, "rst_yr_def", L_Y0, 4'd3, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
